// File: rtl/firc_src_pkg.sv
// Shared widths, defaults and FSM state type for the coefficient-loading sample router.
// Optional feature macro: FIRC_SRC_CNT_EN (downstream sample counter).
package firc_pkg;
  localparam int SAMP_W    = 24;
  localparam int COEF_W    = 27;
  localparam int ADDR_W    = 5;
  localparam int NCOEF_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_COEF,
    STREAM,
    DRAIN
  } state_t;
endpackage

// File: rtl/firc_src_if.sv
// Bus bundle for firc_src: coefficient writes, upstream/downstream sample
// handshakes, coefficient push port and status.
interface firc_src_if;
  import firc_pkg::*;

  logic              CoefWe;
  logic [ADDR_W-1:0] CoefWAddr;
  logic [COEF_W-1:0] CoefWI;
  logic [COEF_W-1:0] CoefWQ;
  logic              LoadReq;
  logic              UPush;
  logic              UStop;
  logic [SAMP_W-1:0] USampI;
  logic [SAMP_W-1:0] USampQ;
  logic              PushIn;
  logic              StopIn;
  logic [SAMP_W-1:0] SampI;
  logic [SAMP_W-1:0] SampQ;
  logic              PushCoef;
  logic [ADDR_W-1:0] CoefAddr;
  logic [COEF_W-1:0] CoefI;
  logic [COEF_W-1:0] CoefQ;
  logic              Busy;
  logic [15:0]       SampCnt;

  modport slave (
    input  CoefWe, CoefWAddr, CoefWI, CoefWQ, LoadReq,
    input  UPush, USampI, USampQ, StopIn,
    output UStop, PushIn, SampI, SampQ,
    output PushCoef, CoefAddr, CoefI, CoefQ,
    output Busy, SampCnt
  );

  modport master (
    output CoefWe, CoefWAddr, CoefWI, CoefWQ, LoadReq,
    output UPush, USampI, USampQ, StopIn,
    input  UStop, PushIn, SampI, SampQ,
    input  PushCoef, CoefAddr, CoefI, CoefQ,
    input  Busy, SampCnt
  );
endinterface

// File: rtl/firc_src_fifo.sv
// Synchronous FIFO with first-word fall-through head; depth must be a power of 2.
// Pointers carry one extra wrap bit to tell full from empty.
module firc_src_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         wr;
  logic         rd;

  assign wr = push && !full;
  assign rd = pop && !empty;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + (AW+1)'(1);
      if (rd) rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (wr) mem[wp[AW-1:0]] <= din;
  end

  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/firc_src.sv
// Sample router that pauses the stream to push a shadow coefficient table downstream.
// Optional: define FIRC_SRC_CNT_EN for a saturating downstream sample counter.
module firc_src
  import firc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int NCOEF      = NCOEF_DEF
) (
  input logic      Clk,
  input logic      Reset,
  firc_src_if.slave bus
);
  localparam int TBL = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NCOEF);

  state_t state_q;
  state_t state_d;

  logic [COEF_W-1:0] shad_i [TBL];
  logic [COEF_W-1:0] shad_q [TBL];
  logic              pcoef_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COEF_W-1:0] ci_q;
  logic [COEF_W-1:0] cq_q;
  logic [ADDR_W-1:0] nxt_addr;
  logic [COEF_W-1:0] rd_i;
  logic [COEF_W-1:0] rd_q;
  logic              wr_en;
  logic              fwd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fwd_state;
  logic              push;
  logic [2*SAMP_W-1:0] head;

  assign fwd_state = (state_q == STREAM) ||
                     (state_q == DRAIN);
  assign bus.UStop  = !Reset &&
                      (fifo_full || state_q == DRAIN);
  assign bus.PushIn = !Reset && fwd_state &&
                      !fifo_empty && !bus.StopIn;
  assign bus.Busy   = !Reset &&
                      (state_q == LOAD_COEF || state_q == DRAIN);
  assign push = bus.UPush && !bus.UStop;

  firc_src_fifo #(
    .W     (2*SAMP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .pop   (bus.PushIn),
    .din   ({bus.USampI, bus.USampQ}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head is masked so nothing stale leaks out of an empty FIFO.
  assign bus.SampI = (!Reset && !fifo_empty) ?
                     head[2*SAMP_W-1:SAMP_W] : '0;
  assign bus.SampQ = (!Reset && !fifo_empty) ?
                     head[SAMP_W-1:0] : '0;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.LoadReq) state_d = LOAD_COEF;
      LOAD_COEF: if (addr_q == LAST) state_d = STREAM;
      STREAM:    if (bus.LoadReq) state_d = DRAIN;
      DRAIN:     if (fifo_empty) state_d = LOAD_COEF;
      default:   state_d = IDLE;
    endcase
  end

  assign wr_en = bus.CoefWe &&
                 bus.CoefWAddr != '0 &&
                 bus.CoefWAddr <= LAST &&
                 (state_q == IDLE || state_q == STREAM);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < TBL; i++) begin
        shad_i[i] <= '0;
        shad_q[i] <= '0;
      end
    end else if (wr_en) begin
      shad_i[bus.CoefWAddr] <= bus.CoefWI;
      shad_q[bus.CoefWAddr] <= bus.CoefWQ;
    end
  end

  // A write landing with LoadReq is forwarded into the first push.
  assign nxt_addr = (state_q == LOAD_COEF) ?
                    addr_q + ADDR_W'(1) : ADDR_W'(1);
  assign fwd  = wr_en && (bus.CoefWAddr == nxt_addr);
  assign rd_i = fwd ? bus.CoefWI : shad_i[nxt_addr];
  assign rd_q = fwd ? bus.CoefWQ : shad_q[nxt_addr];

  always_ff @(posedge Clk) begin
    if (Reset || state_d != LOAD_COEF) begin
      pcoef_q <= 1'b0;
      addr_q  <= '0;
      ci_q    <= '0;
      cq_q    <= '0;
    end else begin
      pcoef_q <= 1'b1;
      addr_q  <= nxt_addr;
      ci_q    <= rd_i;
      cq_q    <= rd_q;
    end
  end

  assign bus.PushCoef = pcoef_q;
  assign bus.CoefAddr = addr_q;
  assign bus.CoefI    = ci_q;
  assign bus.CoefQ    = cq_q;

`ifdef FIRC_SRC_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else if (state_d == LOAD_COEF &&
             state_q != LOAD_COEF) cnt_q <= '0;
    else if (bus.PushIn && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign bus.SampCnt = cnt_q;
`else
  assign bus.SampCnt = '0;
`endif
endmodule

// File: tb/tb_firc_src.sv
// Directed bench for firc_src: load sequence, streaming, back-pressure,
// drain-then-reload, reset mid-load and the optional sample counter.
module tb_firc_src;
  import firc_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int nchk = 0;
  int nerr = 0;

`ifdef FIRC_SRC_CNT_EN
  localparam logic [31:0] CNT20 = 32'd20;
`else
  localparam logic [31:0] CNT20 = 32'd0;
`endif

  firc_src_if bus();

  firc_src #(
    .FIFO_DEPTH (8),
    .NCOEF      (15)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [26:0] cv(input int k);
    return 27'(k * 32'h1000);
  endfunction

  function automatic logic [26:0] cn(input int k);
    return 27'(0) - cv(k);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid();
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_load(input int k, input logic [26:0] ei,
                          input logic [26:0] eq);
    chk($sformatf("pcoef%0d", k), 32'(bus.PushCoef), 32'd1);
    chk($sformatf("caddr%0d", k), 32'(bus.CoefAddr), 32'(k));
    chk($sformatf("coefi%0d", k), 32'(bus.CoefI), 32'(ei));
    chk($sformatf("coefq%0d", k), 32'(bus.CoefQ), 32'(eq));
    chk($sformatf("busyl%0d", k), 32'(bus.Busy), 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pin"}, 32'(bus.PushIn), 32'd0);
    chk({tag, "_pc"}, 32'(bus.PushCoef), 32'd0);
    chk({tag, "_ca"}, 32'(bus.CoefAddr), 32'd0);
    chk({tag, "_ci"}, 32'(bus.CoefI), 32'd0);
    chk({tag, "_cq"}, 32'(bus.CoefQ), 32'd0);
    chk({tag, "_si"}, 32'(bus.SampI), 32'd0);
    chk({tag, "_sq"}, 32'(bus.SampQ), 32'd0);
    chk({tag, "_us"}, 32'(bus.UStop), 32'd0);
    chk({tag, "_bz"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    bus.CoefWe = 0; bus.CoefWAddr = '0;
    bus.CoefWI = '0; bus.CoefWQ = '0;
    bus.LoadReq = 0; bus.UPush = 0;
    bus.USampI = '0; bus.USampQ = '0;
    bus.StopIn = 0;

    // reset and just after
    repeat (2) tick();
    mid();
    chk_quiet("rst");
    tick();
    Reset = 1'b0;
    mid();
    chk_quiet("post");
    chk("post_cnt", 32'(bus.SampCnt), 32'd0);

    // fill shadow, LoadReq with the last write
    for (int a = 1; a <= 15; a++) begin
      tick();
      bus.CoefWe = 1; bus.CoefWAddr = 5'(a);
      bus.CoefWI = cv(a); bus.CoefWQ = cn(a);
      bus.LoadReq = (a == 15);
    end
    tick();
    bus.CoefWe = 0; bus.LoadReq = 0;
    for (int k = 1; k <= 15; k++) begin
      mid();
      chk_load(k, cv(k), cn(k));
      tick();
      bus.CoefWe = (k == 3);
      bus.CoefWAddr = 5'd2;
      bus.CoefWI = 27'h777; bus.CoefWQ = 27'h777;
    end
    bus.CoefWe = 0;
    mid();
    chk("ld_end_pc", 32'(bus.PushCoef), 32'd0);
    chk("ld_end_ca", 32'(bus.CoefAddr), 32'd0);
    chk("ld_end_bz", 32'(bus.Busy), 32'd0);

    // streaming, 1-cycle latency
    tick();
    bus.UPush = 1; bus.USampI = 24'd1; bus.USampQ = 24'h101;
    tick();
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) begin
        bus.USampI = 24'(i + 1);
        bus.USampQ = 24'(i + 1 + 'h100);
      end else bus.UPush = 0;
      mid();
      chk($sformatf("st_pin%0d", i), 32'(bus.PushIn), 32'd1);
      chk($sformatf("st_si%0d", i), 32'(bus.SampI), 32'(i));
      chk($sformatf("st_sq%0d", i), 32'(bus.SampQ), 32'(i + 'h100));
      tick();
    end
    mid();
    chk("st_empty", 32'(bus.PushIn), 32'd0);

    // back-pressure overflow
    tick();
    bus.StopIn = 1;
    for (int i = 0; i < 10; i++) begin
      bus.UPush = 1;
      bus.USampI = 24'('h10 + i); bus.USampQ = 24'('h20 + i);
      mid();
      chk($sformatf("bp_us%0d", i), 32'(bus.UStop), 32'(i >= 8));
      chk($sformatf("bp_pin%0d", i), 32'(bus.PushIn), 32'd0);
      tick();
    end
    bus.UPush = 0; bus.StopIn = 0;
    for (int k = 0; k < 8; k++) begin
      mid();
      chk($sformatf("bp_out%0d", k), 32'(bus.PushIn), 32'd1);
      chk($sformatf("bp_si%0d", k), 32'(bus.SampI), 32'('h10 + k));
      chk($sformatf("bp_sq%0d", k), 32'(bus.SampQ), 32'('h20 + k));
      tick();
    end
    mid();
    chk("bp_done", 32'(bus.PushIn), 32'd0);

    // drain then reload
    tick();
    bus.StopIn = 1;
    for (int i = 0; i < 4; i++) begin
      bus.UPush = 1;
      bus.USampI = 24'('h40 + i); bus.USampQ = 24'('h50 + i);
      tick();
    end
    bus.UPush = 0; bus.LoadReq = 1;
    tick();
    bus.LoadReq = 0;
    bus.UPush = 1; bus.USampI = 24'hBAD; bus.USampQ = 24'hBAD;
    mid();
    chk("dr_busy", 32'(bus.Busy), 32'd1);
    chk("dr_ustop", 32'(bus.UStop), 32'd1);
    chk("dr_hold", 32'(bus.PushIn), 32'd0);
    tick();
    bus.UPush = 0; bus.StopIn = 0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("dr_pin%0d", k), 32'(bus.PushIn), 32'd1);
      chk($sformatf("dr_si%0d", k), 32'(bus.SampI), 32'('h40 + k));
      tick();
    end
    mid();
    chk("dr_empty", 32'(bus.PushIn), 32'd0);
    chk("dr_nopc", 32'(bus.PushCoef), 32'd0);
    chk("dr_busy2", 32'(bus.Busy), 32'd1);
    tick();
    for (int k = 1; k <= 15; k++) begin
      mid();
      chk_load(k, cv(k), cn(k));
      tick();
    end
    mid();
    chk("rl_end_pc", 32'(bus.PushCoef), 32'd0);
    chk("rl_cnt0", 32'(bus.SampCnt), 32'd0);

    // 20 samples for the counter
    tick();
    bus.UPush = 1; bus.USampI = 24'd1; bus.USampQ = 24'd1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      if (i < 20) begin
        bus.USampI = 24'(i + 1); bus.USampQ = 24'(i + 1);
      end else bus.UPush = 0;
      tick();
    end
    mid();
    chk("cnt_pin", 32'(bus.PushIn), 32'd0);
    chk("cnt20", 32'(bus.SampCnt), CNT20);

    // reload, then reset on the 7th push
    tick();
    bus.LoadReq = 1;
    tick();
    bus.LoadReq = 0;
    mid();
    chk("c_drain_bz", 32'(bus.Busy), 32'd1);
    chk("c_drain_cnt", 32'(bus.SampCnt), CNT20);
    tick();
    for (int k = 1; k <= 6; k++) begin
      mid();
      chk_load(k, cv(k), cn(k));
      if (k == 1) chk("c_clr", 32'(bus.SampCnt), 32'd0);
      tick();
    end
    mid();
    chk("r7_addr", 32'(bus.CoefAddr), 32'd7);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    mid();
    chk_quiet("r7");
    tick();
    mid();
    chk("r7_idle_pc", 32'(bus.PushCoef), 32'd0);
    chk("r7_idle_bz", 32'(bus.Busy), 32'd0);

    // table cleared: all-zero load
    tick();
    bus.LoadReq = 1;
    tick();
    bus.LoadReq = 0;
    for (int k = 1; k <= 15; k++) begin
      mid();
      chk_load(k, 27'd0, 27'd0);
      tick();
    end
    mid();
    chk("z_end_pc", 32'(bus.PushCoef), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/firc_src.md
FIRC_SRC -- requirements
Module: firc_src

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning sample FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter NCOEF, default 15, meaning coefficients loaded per sequence (addresses 1..NCOEF).
REQ-003 SHALL have ports as listed below:
- Clk  in  1  single clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- CoefWe  in  1  write strobe into the shadow coefficient table.
- CoefWAddr  in  5  shadow table write address.
- CoefWI / CoefWQ  in  27 each  coefficient data, 3.24 format.
- LoadReq  in  1  one-cycle pulse requesting a coefficient load sequence.
- UPush  in  1  upstream sample valid.
- UStop  out  1  upstream back-pressure.
- USampI / USampQ  in  24 each  upstream sample.
- PushIn  out  1  downstream sample push.
- StopIn  in  1  downstream back-pressure.
- SampI / SampQ  out  24 each  downstream sample.
- PushCoef  out  1  downstream coefficient push.
- CoefAddr  out  5  downstream coefficient address.
- CoefI / CoefQ  out  27 each  downstream coefficient.
- Busy  out  1  high in LOAD_COEF or DRAIN.
- SampCnt  out  16  downstream sample count (see Configuration).

Function
REQ-004 SHALL implement FSM IDLE, LOAD_COEF, STREAM, DRAIN.
REQ-005 IDLE: LoadReq -> LOAD_COEF next cycle; other inputs leave state unchanged.
REQ-006 LOAD_COEF: SHALL drive registered PushCoef=1 for exactly NCOEF consecutive cycles, with CoefAddr=1..NCOEF ascending and CoefI/CoefQ = shadow[CoefAddr]; enters STREAM the cycle after the last push.
REQ-007 PushCoef SHALL be 0 and CoefAddr/CoefI/CoefQ SHALL hold 0 outside LOAD_COEF.
REQ-008 STREAM: PushIn = !fifo_empty && !StopIn (combinational); SampI/SampQ = FIFO head; FIFO pops on every cycle with PushIn=1.
REQ-009 PushIn SHALL be 0 in IDLE and LOAD_COEF; samples SHALL accumulate in the FIFO during those states.
REQ-010 STREAM + LoadReq -> DRAIN; DRAIN forwards samples as in STREAM and forces UStop=1; when FIFO is empty -> LOAD_COEF.
REQ-011 UStop = fifo_full || state==DRAIN; a write occurs iff UPush && !UStop; UPush while UStop=1 SHALL be dropped without error.
REQ-012 A simultaneous write and pop on a non-full FIFO SHALL both occur with occupancy unchanged; FIFO order SHALL be strict FIFO; pointers wrap modulo FIFO_DEPTH.
REQ-013 Minimum latency from an accepted UPush to PushIn SHALL be 1 cycle (empty FIFO, STREAM, StopIn=0).
REQ-014 CoefWe with CoefWAddr in 1..NCOEF SHALL write the shadow table in IDLE or STREAM; writes in LOAD_COEF/DRAIN or to out-of-range addresses SHALL be ignored.
REQ-015 LoadReq outside IDLE/STREAM SHALL be ignored.
REQ-016 The shadow table write in the same cycle as a LoadReq SHALL be visible in the resulting load sequence.

Reset
REQ-017 Reset SHALL set state IDLE, empty the FIFO, and clear the shadow table to 0 and SampCnt to 0.
REQ-018 During and immediately after reset, outputs SHALL be PushIn=0, PushCoef=0, CoefAddr/CoefI/CoefQ/SampI/SampQ=0, UStop=0, Busy=0.
REQ-019 Reset asserted mid-LOAD_COEF or mid-DRAIN SHALL abort the sequence with no further PushCoef or PushIn.

Configuration
REQ-020 With macro FIRC_SRC_CNT_EN defined, SampCnt SHALL increment by 1 per PushIn cycle, saturating at 16'hFFFF, and clear on entry to LOAD_COEF.
REQ-021 Without FIRC_SRC_CNT_EN, SampCnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-022 Package firc_pkg SHALL hold the sample width (24), coefficient width (27), address width (5), NCOEF default, and the FSM state typedef.
REQ-023 The FIFO SHALL be a sub-module firc_src_fifo (params width/depth; ports push, pop, din, dout, full, empty).

Verification
REQ-024 The bench SHALL cover at least the following scenarios:
- Write shadow[1..15]=addr*16'h1000 (I), negated (Q); pulse LoadReq -> 15 PushCoef cycles, addresses 1..15, matching data; then STREAM.
- STREAM, StopIn=0, UPush of 24'h000001..24'h000005 back-to-back -> PushIn with same values, 1-cycle latency each, in order.
- StopIn=1, push 10 samples with FIFO_DEPTH=8 -> UStop=1 after 8, samples 9-10 dropped; release StopIn -> exactly 8 samples out, in order.
- 4 samples buffered, StopIn=1, LoadReq -> DRAIN, Busy=1, UStop=1; StopIn=0 -> 4 PushIn, then 15 PushCoef.
- Reset at the 7th PushCoef -> PushCoef=0 the next cycle, state IDLE, table cleared (next load pushes all zeros).
- FIRC_SRC_CNT_EN defined: 20 samples streamed -> SampCnt=20; LoadReq -> SampCnt=0 after DRAIN.
